mul_arbiter: RTL and testbench

Sequencing and arbitration front-end for the shared array multiplier of the simple ALU. Two requesters compete for one multiplier instance. The block grants one requester at a time round-robin, registers its operands, and drives the signed (Baugh-Wooley) or unsigned array datapath. It captures the 2*WIDTH-bit product with its flags and presents it on a valid/ready response port, tagged with the requester ID.

---
 rtl/mul_arbiter_if.sv | 46 ++++
 rtl/mul_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mul_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// Request/response bundle between two requesters, the multiplier front-end and its consumer.
// Latency: none, wiring only.
// Backpressure: req*_ready from the arbiter, resp_ready from the consumer.
interface mul_arbiter_if #(
    parameter int WIDTH = 4
);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_x;
    logic [WIDTH-1:0]   req0_y;
    logic               req0_signed;

    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_x;
    logic [WIDTH-1:0]   req1_y;
    logic               req1_signed;

    logic               resp_valid;
    logic               resp_ready;
    logic [2*WIDTH-1:0] resp_r;
    logic               resp_id;
    logic               resp_negative;
    logic               resp_zero;
    logic               busy;

    // Requesters plus result consumer side
    modport master (
        output req0_valid, req0_x, req0_y, req0_signed,
        input  req0_ready,
        output req1_valid, req1_x, req1_y, req1_signed,
        input  req1_ready,
        input  resp_valid, resp_r, resp_id, resp_negative, resp_zero, busy,
        output resp_ready
    );

    // Arbiter/multiplier side
    modport slave (
        input  req0_valid, req0_x, req0_y, req0_signed,
        output req0_ready,
        input  req1_valid, req1_x, req1_y, req1_signed,
        output req1_ready,
        output resp_valid, resp_r, resp_id, resp_negative, resp_zero, busy,
        input  resp_ready
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter feeding one shared signed (Baugh-Wooley) / unsigned array multiplier.
// Latency: accept at T0, product registered at T1, held until the response handshake.
// Backpressure: resp_ready low holds DONE; both requesters see ready=0 outside IDLE.
module mul_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_arbiter_if.slave  bus
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] op_x_q, op_x_d;
    logic [WIDTH-1:0] op_y_q, op_y_d;
    logic             op_signed_q, op_signed_d;
    logic             op_id_q, op_id_d;
    logic             resp_valid_q, resp_valid_d;
    logic [PW-1:0]    resp_r_q, resp_r_d;
    logic             resp_id_q, resp_id_d;
    logic             resp_negative_q, resp_negative_d;
    logic             resp_zero_q, resp_zero_d;
    logic             busy_q, busy_d;

    logic             gnt0, gnt1;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    row;
    logic [PW-1:0]    bw_corr;
    logic             pp;

    // Combinational arbitration in IDLE; on a tie the requester that did not win last time goes.
    // Grants are forced low while reset is asserted so nobody sees ready during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Array multiplier: one partial-product row per y bit, accumulated row by row.
    // Signed mode uses Baugh-Wooley: the cross terms with exactly one sign bit are
    // inverted and the constant 2^WIDTH + 2^(PW-1) is added, giving an exact PW-bit result.
    always_comb begin
        prod    = '0;
        row     = '0;
        pp      = 1'b0;
        bw_corr = '0;
        bw_corr[WIDTH]  = 1'b1;
        bw_corr[PW-1]   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            row = '0;
            for (int j = 0; j < WIDTH; j++) begin
                pp = op_x_q[j] & op_y_q[i];
                if (op_signed_q && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
                    pp = ~pp;
                end
                row[i+j] = pp;
            end
            prod = prod + row;
        end
        if (op_signed_q) begin
            prod = prod + bw_corr;
        end
    end

    // Next-state and register-update logic for the IDLE -> BUSY -> DONE sequence.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        op_x_d          = op_x_q;
        op_y_d          = op_y_q;
        op_signed_d     = op_signed_q;
        op_id_d         = op_id_q;
        resp_valid_d    = resp_valid_q;
        resp_r_d        = resp_r_q;
        resp_id_d       = resp_id_q;
        resp_negative_d = resp_negative_q;
        resp_zero_d     = resp_zero_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    op_x_d       = gnt1 ? bus.req1_x      : bus.req0_x;
                    op_y_d       = gnt1 ? bus.req1_y      : bus.req0_y;
                    op_signed_d  = gnt1 ? bus.req1_signed : bus.req0_signed;
                    op_id_d      = gnt1;
                    last_grant_d = gnt1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                resp_r_d        = prod;
                resp_negative_d = op_signed_q & prod[PW-1];
                resp_zero_d     = (prod == '0);
                resp_id_d       = op_id_q;
                resp_valid_d    = 1'b1;
                state_d         = DONE;
            end
            DONE: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // All state registers; reset drops any in-flight operation and primes requester 0 to win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            last_grant_q    <= 1'b1;
            op_x_q          <= '0;
            op_y_q          <= '0;
            op_signed_q     <= 1'b0;
            op_id_q         <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_r_q        <= '0;
            resp_id_q       <= 1'b0;
            resp_negative_q <= 1'b0;
            resp_zero_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            op_x_q          <= op_x_d;
            op_y_q          <= op_y_d;
            op_signed_q     <= op_signed_d;
            op_id_q         <= op_id_d;
            resp_valid_q    <= resp_valid_d;
            resp_r_q        <= resp_r_d;
            resp_id_q       <= resp_id_d;
            resp_negative_q <= resp_negative_d;
            resp_zero_q     <= resp_zero_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_r        = resp_r_q;
    assign bus.resp_id       = resp_id_q;
    assign bus.resp_negative = resp_negative_q;
    assign bus.resp_zero     = resp_zero_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed test-plan cases plus randomized traffic against a scoreboard.
// Latency: expects the result one cycle after accept, held until the resp handshake.
// Backpressure: random and directed resp_ready stalls.
module tb_mul_arbiter;
    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_arbiter_if #(.WIDTH(W)) bus();

    mul_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [PW-1:0] r;
        logic          id;
        logic          neg;
        logic          zero;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic dut_ids[$];
    int   m_phase = 0;     // 0 waiting for accept, 1 computing, 2 result presented
    logic m_last  = 1'b1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endfunction

    // Reference product from plain integer arithmetic
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic s, logic id);
        int   a, b, p;
        exp_t e;
        if (s) begin
            a = $signed(x);
            b = $signed(y);
        end else begin
            a = int'(x);
            b = int'(y);
        end
        p      = a * b;
        e.r    = p[PW-1:0];
        e.id   = id;
        e.neg  = s & e.r[PW-1];
        e.zero = (e.r == '0);
        return e;
    endfunction

    // Monitor: checks the handshake rules and the presented result, then advances the model
    // to what the next rising edge should do (inputs only change just after rising edges).
    always @(negedge clk) begin
        logic er0, er1;
        exp_t f;
        if (!rst_n) begin
            sb.delete();
            m_phase = 0;
            m_last  = 1'b1;
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_rdy0", bus.req0_ready, 0);
            chk("rst_rdy1", bus.req1_ready, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_resp_r", bus.resp_r, 0);
            chk("rst_resp_id", bus.resp_id, 0);
            chk("rst_neg", bus.resp_negative, 0);
            chk("rst_zero", bus.resp_zero, 0);
        end else begin
            er0 = (m_phase == 0) && bus.req0_valid && (!bus.req1_valid || m_last);
            er1 = (m_phase == 0) && bus.req1_valid && (!bus.req0_valid || !m_last);
            chk("rdy0", bus.req0_ready, er0);
            chk("rdy1", bus.req1_ready, er1);
            chk("rdy_exclusive", bus.req0_ready & bus.req1_ready, 0);
            chk("busy", bus.busy, m_phase != 0);
            chk("resp_valid", bus.resp_valid, m_phase == 2);
            if (m_phase == 2) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    f = sb[0];
                    chk("resp_r", bus.resp_r, f.r);
                    chk("resp_id", bus.resp_id, f.id);
                    chk("resp_neg", bus.resp_negative, f.neg);
                    chk("resp_zero", bus.resp_zero, f.zero);
                end
            end
            if (bus.resp_valid && bus.resp_ready) dut_ids.push_back(bus.resp_id);
            case (m_phase)
                0: begin
                    if (er0) begin
                        sb.push_back(model(bus.req0_x, bus.req0_y, bus.req0_signed, 1'b0));
                        m_last = 1'b0;
                        m_phase = 1;
                    end else if (er1) begin
                        sb.push_back(model(bus.req1_x, bus.req1_y, bus.req1_signed, 1'b1));
                        m_last = 1'b1;
                        m_phase = 1;
                    end
                end
                1: m_phase = 2;
                default: begin
                    if (bus.resp_ready) begin
                        if (sb.size() > 0) void'(sb.pop_front());
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic wait_rdy0(string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req0_ready && n < 20);
        chk(nm, bus.req0_ready, 1);
    endtask

    // Single requester-0 operation with constant expected result and one-cycle latency check
    task automatic directed(string nm, logic [W-1:0] x, logic [W-1:0] y, logic s,
                            logic [PW-1:0] er, logic en, logic ez);
        @(posedge clk); #1;
        bus.req1_valid  = 1'b0;
        bus.req0_valid  = 1'b1;
        bus.req0_x      = x;
        bus.req0_y      = y;
        bus.req0_signed = s;
        bus.resp_ready  = 1'b1;
        wait_rdy0({nm, "_grant"});
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid_t0"}, bus.resp_valid, 0);
        @(negedge clk);
        chk({nm, "_valid_t1"}, bus.resp_valid, 1);
        chk({nm, "_r"}, bus.resp_r, er);
        chk({nm, "_neg"}, bus.resp_negative, en);
        chk({nm, "_zero"}, bus.resp_zero, ez);
        chk({nm, "_id"}, bus.resp_id, 0);
    endtask

    initial begin
        exp_t cap;
        int   n;
        bus.req0_valid = 0; bus.req0_x = '0; bus.req0_y = '0; bus.req0_signed = 0;
        bus.req1_valid = 0; bus.req1_x = '0; bus.req1_y = '0; bus.req1_signed = 0;
        bus.resp_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        directed("sgn_mul",   4'b1101, 4'b0011, 1'b1, 8'hF7, 1'b1, 1'b0);
        directed("uns_mul",   4'b1101, 4'b0011, 1'b0, 8'h27, 1'b0, 1'b0);
        directed("sgn_minmin", 4'b1000, 4'b1000, 1'b1, 8'h40, 1'b0, 1'b0);
        directed("uns_maxmax", 4'hF, 4'hF, 1'b0, 8'hE1, 1'b0, 1'b0);
        directed("zero_flag", 4'h0, 4'h9, 1'b1, 8'h00, 1'b0, 1'b1);

        // Backpressure: hold the result with resp_ready low while requester 1 waits
        @(posedge clk); #1;
        bus.resp_ready  = 1'b0;
        bus.req0_valid  = 1'b1;
        bus.req0_x      = 4'h6;
        bus.req0_y      = 4'hB;
        bus.req0_signed = 1'b0;
        wait_rdy0("bp_grant");
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_x     = 4'h3;
        bus.req1_y     = 4'h2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.resp_valid && n < 20);
        chk("bp_valid", bus.resp_valid, 1);
        chk("bp_r", bus.resp_r, 8'h42);
        cap = '{r: bus.resp_r, id: bus.resp_id, neg: bus.resp_negative, zero: bus.resp_zero};
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.resp_valid, 1);
            chk("bp_hold_r", bus.resp_r, cap.r);
            chk("bp_hold_id", bus.resp_id, cap.id);
            chk("bp_hold_flags", {bus.resp_negative, bus.resp_zero}, {cap.neg, cap.zero});
            chk("bp_hold_busy", bus.busy, 1);
            chk("bp_hold_rdy", {bus.req0_ready, bus.req1_ready}, 0);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pre_release_busy", bus.busy, 1);
        @(negedge clk);
        chk("bp_idle_busy", bus.busy, 0);
        chk("bp_idle_valid", bus.resp_valid, 0);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        repeat (4) @(posedge clk);

        // Reset while an operation is in BUSY
        #1;
        bus.req0_valid  = 1'b1;
        bus.req0_x      = 4'h5;
        bus.req0_y      = 4'h5;
        bus.req0_signed = 1'b0;
        wait_rdy0("rm_grant");
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        rst_n = 1'b0;
        // Round-robin setup: both requesters valid with distinct operands across the release
        bus.req0_valid  = 1'b1;
        bus.req0_x      = 4'h3;
        bus.req0_y      = 4'h5;
        bus.req0_signed = 1'b0;
        bus.req1_valid  = 1'b1;
        bus.req1_x      = 4'hE;
        bus.req1_y      = 4'h7;
        bus.req1_signed = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rm_no_valid", bus.resp_valid, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dut_ids.delete();
        repeat (20) @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("rr_count_ge4", dut_ids.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < dut_ids.size()) chk("rr_id_seq", dut_ids[i], i % 2);
        end
        repeat (4) @(posedge clk);

        // Randomized traffic with random stalls
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.req0_valid  = $urandom_range(0, 1);
            bus.req0_x      = W'($urandom);
            bus.req0_y      = W'($urandom);
            bus.req0_signed = $urandom_range(0, 1);
            bus.req1_valid  = $urandom_range(0, 1);
            bus.req1_x      = W'($urandom);
            bus.req1_y      = W'($urandom);
            bus.req1_signed = $urandom_range(0, 1);
            bus.resp_ready  = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
